// File: rtl/nv_nvdla_reg_dual_pkg.sv
// Shared offsets, STATUS/POINTER bit positions and reset constants for the dual ping-pong config register file.
package nv_nvdla_reg_dual_pkg;

    localparam int unsigned REG_AW = 12;
    localparam int unsigned REG_DW = 32;

    localparam logic [REG_AW-1:0] PTR_OFS_DEF = 12'h000;
    localparam logic [REG_AW-1:0] STS_OFS_DEF = 12'h004;
    // Group block layout, relative to BASE: OP_ENABLE first, then CFG_k at 4+4k
    localparam logic [REG_AW-1:0] OPEN_REL    = 12'h000;
    localparam int unsigned       CFG_REL0    = 4;
    localparam int unsigned       CFG_STRIDE  = 4;

    localparam int unsigned PTR_PROD_BIT    = 0;
    localparam int unsigned PTR_CONS_BIT    = 16;
    localparam int unsigned STS_WR_LOCK_BIT = 16;
    localparam int unsigned STS_SPUR_BIT    = 17;

    localparam int unsigned  PROC_PREC_LSB = 12;
    localparam int unsigned  PROC_PREC_W   = 2;
    localparam logic [PROC_PREC_W-1:0] PROC_PREC_RST = 2'b01;
    localparam logic [REG_DW-1:0] CFG_WORD_RST = 32'(PROC_PREC_RST) << PROC_PREC_LSB;

    typedef struct packed {
        logic [REG_AW-1:0] offset;
        logic [REG_DW-1:0] data;
    } reg_wr_t;

    function automatic logic [REG_DW-1:0] ptr_word(input logic prod, input logic cons);
        logic [REG_DW-1:0] w;
        w = '0;
        w[PTR_PROD_BIT] = prod;
        w[PTR_CONS_BIT] = cons;
        return w;
    endfunction

endpackage

// File: rtl/nv_nvdla_reg_dual_pingpong_if.sv
// CSB register port plus datapath launch/done handshake of the dual ping-pong register file.
interface nv_nvdla_reg_dual_pingpong_if #(
    parameter int unsigned NUM_CFG = 2
);
    logic [11:0]            reg_offset;
    logic [31:0]            reg_wr_data;
    logic                   reg_wr_en;
    logic [31:0]            reg_rd_data;
    logic                   op_done;
    logic                   op_valid;
    logic                   op_start;
    logic                   op_group;
    logic [32*NUM_CFG-1:0]  cfg_out;
    logic                   err_irq;

    modport master (
        output reg_offset, reg_wr_data, reg_wr_en, op_done,
        input  reg_rd_data, op_valid, op_start, op_group, cfg_out, err_irq
    );

    modport slave (
        input  reg_offset, reg_wr_data, reg_wr_en, op_done,
        output reg_rd_data, op_valid, op_start, op_group, cfg_out, err_irq
    );
endinterface

// File: rtl/nv_nvdla_reg_dual_group.sv
// One config group: NUM_CFG config flops plus its op_en flop.
// NVDLA_REG_DUAL_WR_LOCK_EN: drop CFG writes while op_en=1 and flag lock_err_c.
module nv_nvdla_reg_dual_group
    import nv_nvdla_reg_dual_pkg::*;
#(
    parameter int unsigned          NUM_CFG = 2,
    parameter int unsigned          IDX_W   = 1,
    parameter logic [32*NUM_CFG-1:0] CFG_RST = {NUM_CFG{CFG_WORD_RST}}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we_i,
    input  logic [IDX_W-1:0]            cfg_idx_i,
    input  logic [31:0]                 cfg_wdata_i,
    input  logic                        en_set_i,
    input  logic                        en_clr_i,
    output logic [NUM_CFG-1:0][31:0]    cfg_o,
    output logic                        op_en_o,
    output logic                        op_en_nxt_c,
    output logic                        lock_err_c
);

    logic [NUM_CFG-1:0][31:0] cfg_q, cfg_d;
    logic                     op_en_q, op_en_d;
    logic                     cfg_wr_ok;

    always_comb begin
`ifdef NVDLA_REG_DUAL_WR_LOCK_EN
        lock_err_c = cfg_we_i & op_en_q;
        cfg_wr_ok  = cfg_we_i & ~op_en_q;
`else
        lock_err_c = 1'b0;
        cfg_wr_ok  = cfg_we_i;
`endif
        cfg_d = cfg_q;
        if (cfg_wr_ok) begin
            cfg_d[cfg_idx_i] = cfg_wdata_i;
        end
        // set (from an OP_ENABLE write) only happens while the bit is 0, clear only while it is 1
        op_en_d = (op_en_q & ~en_clr_i) | en_set_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q   <= CFG_RST;
            op_en_q <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            op_en_q <= op_en_d;
        end
    end

    assign cfg_o       = cfg_q;
    assign op_en_o     = op_en_q;
    assign op_en_nxt_c = op_en_d;

endmodule

// File: rtl/nv_nvdla_reg_dual_pingpong.sv
// Dual-group ping-pong config register file: pointers, register decode/read mux, STATUS and op_start.
// NVDLA_REG_DUAL_WR_LOCK_EN enables CFG write locking on the group being consumed.
module nv_nvdla_reg_dual_pingpong
    import nv_nvdla_reg_dual_pkg::*;
#(
    parameter int unsigned           NUM_CFG = 2,
    parameter logic [11:0]           BASE    = 12'h008,
    parameter logic [11:0]           PTR_OFS = PTR_OFS_DEF,
    parameter logic [11:0]           STS_OFS = STS_OFS_DEF,
    parameter logic [32*NUM_CFG-1:0] CFG_RST = {NUM_CFG{CFG_WORD_RST}}
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rstn,
    nv_nvdla_reg_dual_pingpong_if.slave   bus
);

    localparam int unsigned IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

    reg_wr_t              wr;
    logic [11:0]          rel;
    logic [9:0]           cfg_k;
    logic [IDX_W-1:0]     cfg_idx;
    logic                 hit_ptr, hit_sts, hit_open, hit_cfg;
    logic                 wr_ptr, wr_sts, wr_open, wr_cfg;
    logic                 op_valid_c, done_ok, spur_done;

    logic                 producer_q, producer_d;
    logic                 consumer_q, consumer_d;
    logic                 err_lock_q, err_lock_d;
    logic                 err_spur_q, err_spur_d;
    logic                 start_q, start_d;

    logic [1:0]           op_en, op_en_nxt, lock_err, en_set, en_clr, cfg_we;
    logic [NUM_CFG-1:0][31:0] cfg_grp [2];
    logic [31:0]          rd_data;

    for (genvar g = 0; g < 2; g++) begin : g_grp
        nv_nvdla_reg_dual_group #(
            .NUM_CFG (NUM_CFG),
            .IDX_W   (IDX_W),
            .CFG_RST (CFG_RST)
        ) u_group (
            .clk         (nvdla_core_clk),
            .rst_n       (nvdla_core_rstn),
            .cfg_we_i    (cfg_we[g]),
            .cfg_idx_i   (cfg_idx),
            .cfg_wdata_i (wr.data),
            .en_set_i    (en_set[g]),
            .en_clr_i    (en_clr[g]),
            .cfg_o       (cfg_grp[g]),
            .op_en_o     (op_en[g]),
            .op_en_nxt_c (op_en_nxt[g]),
            .lock_err_c  (lock_err[g])
        );
    end

    // Address decode; POINTER and STATUS take priority over the group block
    always_comb begin
        wr       = '{offset: bus.reg_offset, data: bus.reg_wr_data};
        rel      = wr.offset - BASE;
        cfg_k    = rel[11:2] - 10'd1;
        cfg_idx  = cfg_k[IDX_W-1:0];
        hit_ptr  = (wr.offset == PTR_OFS);
        hit_sts  = !hit_ptr && (wr.offset == STS_OFS);
        hit_open = !hit_ptr && !hit_sts && (rel == OPEN_REL);
        hit_cfg  = !hit_ptr && !hit_sts && !hit_open && (rel[1:0] == 2'b00) &&
                   (rel[11:2] != 10'd0) && (cfg_k < 10'(NUM_CFG));
        wr_ptr   = bus.reg_wr_en & hit_ptr;
        wr_sts   = bus.reg_wr_en & hit_sts;
        wr_open  = bus.reg_wr_en & hit_open;
        wr_cfg   = bus.reg_wr_en & hit_cfg;
    end

    // Pointer, error and launch next-state
    always_comb begin
        op_valid_c = op_en[consumer_q];
        done_ok    = bus.op_done & op_valid_c;
        spur_done  = bus.op_done & ~op_valid_c;
        en_set     = '0;
        en_clr     = '0;
        cfg_we     = '0;
        for (int g = 0; g < 2; g++) begin
            en_set[g] = wr_open & wr.data[0] & ~op_en[g] & (producer_q == 1'(g));
            en_clr[g] = done_ok & (consumer_q == 1'(g));
            cfg_we[g] = wr_cfg & (producer_q == 1'(g));
        end
        producer_d = wr_ptr ? wr.data[PTR_PROD_BIT] : producer_q;
        consumer_d = consumer_q ^ done_ok;
        err_lock_d = (err_lock_q & ~(wr_sts & wr.data[STS_WR_LOCK_BIT])) | (|lock_err);
        err_spur_d = (err_spur_q & ~(wr_sts & wr.data[STS_SPUR_BIT])) | spur_done;
        // first cycle of a valid episode: either a fresh enable or a back-to-back hand-over
        start_d    = op_en_nxt[consumer_d] & (~op_valid_c | done_ok);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            producer_q <= 1'b0;
            consumer_q <= 1'b0;
            err_lock_q <= 1'b0;
            err_spur_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            producer_q <= producer_d;
            consumer_q <= consumer_d;
            err_lock_q <= err_lock_d;
            err_spur_q <= err_spur_d;
            start_q    <= start_d;
        end
    end

    // Read mux; group block reads follow the producer
    always_comb begin
        rd_data = '0;
        if (hit_ptr) begin
            rd_data = ptr_word(producer_q, consumer_q);
        end else if (hit_sts) begin
            rd_data[1:0]            = op_en;
            rd_data[STS_WR_LOCK_BIT] = err_lock_q;
            rd_data[STS_SPUR_BIT]    = err_spur_q;
        end else if (hit_open) begin
            rd_data[0] = op_en[producer_q];
        end else if (hit_cfg) begin
            rd_data = cfg_grp[producer_q][cfg_idx];
        end
    end

    assign bus.reg_rd_data = rd_data;
    assign bus.op_valid    = op_en[consumer_q];
    assign bus.op_start    = start_q;
    assign bus.op_group    = consumer_q;
    assign bus.cfg_out     = consumer_q ? cfg_grp[1] : cfg_grp[0];
    assign bus.err_irq     = err_lock_q | err_spur_q;

endmodule
